// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle for mux_nto1_pipe: producer side (din/sel/in_valid), consumer side
// (dout/out_valid/out_ready) and the debug status outputs.
interface mux_nto1_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [WIDTH*NUM_IN-1:0] din;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        dout;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [15:0]             xfer_cnt;

  modport master (
    output din, sel, in_valid, out_ready,
    input  in_ready, dout, out_valid, sel_err, xfer_cnt
  );

  modport slave (
    input  din, sel, in_valid, out_ready,
    output in_ready, dout, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 select with valid/ready handshake and a 2-entry skid buffer.
// Optional macro MUX_SEL_CHECK_EN enables the sticky out-of-range select flag sel_err.
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
) (
  input logic             clk,
  input logic             reset,
  mux_nto1_pipe_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic [WIDTH-1:0] word;
  logic             in_ready;
  logic             out_valid;
  logic             in_fire;
  logic             out_fire;

  // Out-of-range selects fall through every compare and yield an all-zero word.
  function automatic logic [WIDTH-1:0] select_word(input logic [WIDTH*NUM_IN-1:0] d,
                                                   input logic [SEL_W-1:0]        s);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (s == SEL_W'(i)) w = d[i*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  assign word     = select_word(bus.din, bus.sel);
  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire)      state_d = TWO;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      TWO:     if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Main always holds the oldest word; skid only ever fills while main is stalled.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      EMPTY: if (in_fire) main_d = word;
      ONE: begin
        if (in_fire && out_fire) main_d = word;
        else if (in_fire)        skid_d = word;
      end
      TWO:     if (out_fire) main_d = skid_q;
      default: ;
    endcase
  end

  assign xfer_cnt_d = xfer_cnt_q + 16'(out_fire);

  // Handshake outputs come from registered state only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dout      = main_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;
  logic sel_in_range;

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (s == SEL_W'(i)) ok = 1'b1;
    end
    return ok;
  endfunction

  assign sel_in_range = sel_ok(bus.sel);
  assign sel_err_d    = sel_err_q | (in_fire & ~sel_in_range);

  always_ff @(posedge clk) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe: a 4-input instance driven from a vector table and
// a 3-input instance for out-of-range selects, plus reset-in-TWO and counter wrap sequences.
module tb_mux_nto1_pipe;
`ifdef MUX_SEL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mux_nto1_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  mux_nto1_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  mux_nto1_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        iv;
    logic        orr;
    logic        ev;
    logic [31:0] ed;
    logic        er;
    logic [15:0] ex;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(input logic [1:0] sel, input logic iv, input logic orr,
                              input logic ev, input logic [31:0] ed, input logic er,
                              input logic [15:0] ex);
    vec_t v;
    v.sel = sel; v.iv = iv; v.orr = orr;
    v.ev = ev; v.ed = ed; v.er = er; v.ex = ex;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus4.din       = 128'h00000044_00000033_00000022_00000011;
    bus4.sel       = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus3.din       = 96'h00000033_00000022_00000011;
    bus3.sel       = '0;
    bus3.in_valid  = 1'b0;
    bus3.out_ready = 1'b0;

    vt[0]  = mk(2'd2, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 16'd0);
    vt[1]  = mk(2'd0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 16'd1);
    vt[2]  = mk(2'd0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b1, 16'd1);
    vt[3]  = mk(2'd1, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 16'd2);
    vt[4]  = mk(2'd2, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 16'd3);
    vt[5]  = mk(2'd3, 1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 16'd4);
    vt[6]  = mk(2'd0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 16'd5);
    vt[7]  = mk(2'd0, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 16'd5);
    vt[8]  = mk(2'd1, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 16'd5);
    vt[9]  = mk(2'd2, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 16'd5);
    vt[10] = mk(2'd2, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 16'd5);
    vt[11] = mk(2'd2, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 16'd6);
    vt[12] = mk(2'd2, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 16'd7);
    vt[13] = mk(2'd0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 16'd8);
    vt[14] = mk(2'd3, 1'b1, 1'b0, 1'b1, 32'h44, 1'b1, 16'd8);
    vt[15] = mk(2'd0, 1'b0, 1'b0, 1'b1, 32'h44, 1'b1, 16'd8);
    vt[16] = mk(2'd0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 16'd9);

    tick();
    tick();
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus4.in_ready),  32'd1);
    check("rst_dout",      bus4.dout,           32'd0);
    check("rst_xfer_cnt",  32'(bus4.xfer_cnt),  32'd0);
    check("rst_sel_err",   32'(bus3.sel_err),   32'd0);
    check("rst3_in_ready", 32'(bus3.in_ready),  32'd1);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus4.sel       = vt[i].sel;
      bus4.in_valid  = vt[i].iv;
      bus4.out_ready = vt[i].orr;
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(bus4.out_valid), 32'(vt[i].ev));
      check($sformatf("vec%0d_dout", i),      bus4.dout,           vt[i].ed);
      check($sformatf("vec%0d_in_ready", i),  32'(bus4.in_ready),  32'(vt[i].er));
      check($sformatf("vec%0d_xfer_cnt", i),  32'(bus4.xfer_cnt),  32'(vt[i].ex));
    end
    bus4.in_valid = 1'b0;

    // Out-of-range select on the 3-input instance.
    bus3.out_ready = 1'b1;
    bus3.in_valid  = 1'b1;
    bus3.sel       = 2'd1;
    tick();
    check("sel3_inrange_dout", bus3.dout,          32'h22);
    check("sel3_inrange_err",  32'(bus3.sel_err),  32'd0);
    bus3.sel = 2'd3;
    tick();
    check("sel3_oor_valid", 32'(bus3.out_valid), 32'd1);
    check("sel3_oor_dout",  bus3.dout,           32'd0);
    check("sel3_oor_err",   32'(bus3.sel_err),   32'(CHK));
    bus3.sel = 2'd0;
    tick();
    check("sel3_after_dout", bus3.dout,         32'h11);
    check("sel3_after_err",  32'(bus3.sel_err), 32'(CHK));
    bus3.in_valid = 1'b0;
    tick();
    tick();
    check("sel3_sticky_err", 32'(bus3.sel_err), 32'(CHK));
    check("sel4_pow2_err",   32'(bus4.sel_err), 32'd0);

    // Fill both registers, then reset while in TWO.
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.sel       = 2'd3;
    tick();
    bus4.sel = 2'd2;
    tick();
    check("two_in_ready", 32'(bus4.in_ready), 32'd0);
    check("two_dout",     bus4.dout,          32'h44);
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    reset = 1'b1;
    tick();
    check("rst2_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst2_in_ready",  32'(bus4.in_ready),  32'd1);
    check("rst2_xfer_cnt",  32'(bus4.xfer_cnt),  32'd0);
    check("rst2_dout",      bus4.dout,           32'd0);
    check("rst2_sel_err",   32'(bus3.sel_err),   32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst%0d_out_valid", i), 32'(bus4.out_valid), 32'd0);
      check($sformatf("post_rst%0d_in_ready", i),  32'(bus4.in_ready),  32'd1);
      check($sformatf("post_rst%0d_xfer_cnt", i),  32'(bus4.xfer_cnt),  32'd0);
    end

    // Counter wrap: first accept fills main, every later cycle is an output fire.
    bus4.sel       = 2'd1;
    bus4.in_valid  = 1'b1;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) tick();
    check("wrap_pre_cnt",   32'(bus4.xfer_cnt),  32'h0000FFFF);
    check("wrap_pre_valid", 32'(bus4.out_valid), 32'd1);
    tick();
    check("wrap_cnt",  32'(bus4.xfer_cnt), 32'h00000000);
    check("wrap_dout", bus4.dout,          32'h22);
    bus4.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 registered datapath multiplexer with a valid/ready handshake and a 2-entry skid buffer on the output. It is the next-generation operand/result select for the CPU datapath: it replaces fixed-width 2:1 combinational selects wherever a select must be registered and the consumer can stall. It carries an optional out-of-range select check with a sticky error flag, plus a transfer counter for debug.

## Interface
- WIDTH, 32: data width of each input and of the output.
- NUM_IN, 4: number of data inputs, 2..16.
- SEL_W, $clog2(NUM_IN): select width, derived; not overridden.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- din  input  WIDTH*NUM_IN  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SEL_W  input index, sampled with in_valid.
- in_valid  input  1  producer offers din/sel.
- in_ready  output  1  block accepts this cycle.
- dout  output  WIDTH  selected data, registered.
- out_valid  output  1  dout holds a valid word.
- out_ready  input  1  consumer accepts dout.
- sel_err  output  1  sticky out-of-range select flag (see Configuration).
- xfer_cnt  output  16  count of output transfers, wraps.

## Operation
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Selected word = din[sel] when sel < NUM_IN; all-zero otherwise.
- There are two storage registers: main (drives dout) and skid.
- State is encoded as EMPTY, ONE (main full), or TWO (main + skid full).
- EMPTY: input fire loads the selected word into main and moves to ONE.
- ONE, input fire and output fire: main is loaded with the new word; state stays ONE.
- ONE, input fire only: skid is loaded with the new word; state moves to TWO.
- ONE, output fire only: state moves to EMPTY.
- ONE, no fire: hold.
- TWO: in_ready=0. Output fire copies skid into main and moves to ONE. Otherwise hold.
- in_ready = (state != TWO), decoded from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). dout = main.
- Data order is strictly FIFO. No word is dropped or duplicated.
- xfer_cnt increments by 1 on each output fire and wraps 0xFFFF -> 0x0000.
- Word contents are never modified beyond selection. The select is resolved at input fire, so later changes to sel do not affect stored words.

## Timing
- Latency: a word accepted at edge k is on dout with out_valid=1 after edge k (1 cycle), when main was empty or draining.
- Throughput: 1 word/cycle with out_ready held high.
- Reset (synchronous, wins over all other events in that cycle) sets:
  - state=EMPTY, out_valid=0, in_ready=1, dout=0;
  - skid contents=0, sel_err=0, xfer_cnt=0.
- Reset mid-operation: all buffered words are discarded. in_ready is 1 in the first cycle after reset deasserts.
- Simultaneous input and output fire in ONE: both take effect on the same edge, with no bubble.
- While out_valid=1 and out_ready=0, dout is stable.
- out_valid is only deasserted after an output fire.
- in_valid may drop without a fire; the block does not require it to be held.

## Configuration
- MUX_SEL_CHECK_EN defined:
  - On an input fire with sel >= NUM_IN, sel_err is set to 1 on the next edge and stays at 1 until reset.
  - The word (all-zero) is still passed through.
- MUX_SEL_CHECK_EN undefined:
  - The check logic is omitted and sel_err is tied to 0.
  - Out-of-range selects still yield all-zero words.
- The macro has no effect when NUM_IN is a power of two, because no out-of-range value exists; sel_err then stays 0.

## Test plan
- Reset, then NUM_IN=4, WIDTH=32, din={0x44,0x33,0x22,0x11}, sel=2, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, dout=0x33; xfer_cnt=1 after the following edge.
- Stream sel=0,1,2,3 on consecutive cycles with out_ready=1 -> dout=0x11,0x22,0x33,0x44 on consecutive cycles, and in_ready stays 1.
- Backpressure: out_ready=0, offer words A,B,C -> A in main, B in skid, in_ready=0 after the 2nd accept and C held off. Raise out_ready -> A,B,C emerge in order and no word is lost.
- NUM_IN=3, sel=3 with MUX_SEL_CHECK_EN -> dout=0, sel_err=1 and staying 1. Without the macro -> dout=0, sel_err=0.
- Reset asserted while in state TWO -> out_valid=0, in_ready=1, xfer_cnt=0 on the next cycle, and the old words never appear.
- Preload xfer_cnt to 0xFFFF by 65535 transfers, then make one more transfer -> xfer_cnt=0x0000.
